// File: rtl/fan_speed_ctrl.sv
// Four-state fan speed controller (OFF, LOW, MID, HIGH) driven by five push buttons.
// Each raw button is synchronised through two flops, debounced by a per-bit counter,
// and edge-detected. A new press moves the FSM once. The state is shown one-hot on four LEDs.
module fan_speed_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int CNT_W           = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_button,
  output logic [3:0] o_Led
);

  localparam int NB = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_MID  = 2'd2,
    ST_HIGH = 2'd3
  } state_e;

  // Button indices
  localparam int B_OFF   = 0;
  localparam int B_LOW   = 1;
  localparam int B_MID   = 2;
  localparam int B_HIGH  = 3;
  localparam int B_CYCLE = 4;

  logic [NB-1:0]    meta_q, sync_q;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [NB-1:0]    deb_q, deb_d;
  logic [NB-1:0]    deb_prev_q;
  logic [NB-1:0]    press;
  state_e           state_q, state_d;
  logic [3:0]       led_q;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // values from before the edge; blocking here would collapse the two stages into one.
    if (i_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_button;
      sync_q <= meta_q;
    end
  end

  // Debounce next-state: count while synchronised level differs, commit on the last count.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounce counters, debounced levels and the edge-detect history register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the counter array is small and all of it must clear, so it is reset
      // element by element; a large RAM-style array would normally be left unreset.
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  // Rising edge of a debounced level is a one-clock press pulse; releases are ignored.
  assign press = deb_q & ~deb_prev_q;

  // Next state: lowest button index wins, so OFF has top priority and CYCLE the lowest.
  always_comb begin
    state_d = state_q;
    if (press[B_OFF]) begin
      state_d = ST_OFF;
    end else if (press[B_LOW]) begin
      state_d = ST_LOW;
    end else if (press[B_MID]) begin
      state_d = ST_MID;
    end else if (press[B_HIGH]) begin
      state_d = ST_HIGH;
    end else if (press[B_CYCLE]) begin
      case (state_q)
        ST_OFF:  state_d = ST_LOW;
        ST_LOW:  state_d = ST_MID;
        ST_MID:  state_d = ST_HIGH;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State register and registered one-hot LED decode, updated together so the LEDs never glitch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_OFF;
      led_q   <= 4'b0001;
    end else begin
      state_q <= state_d;
      case (state_d)
        ST_OFF:  led_q <= 4'b0001;
        ST_LOW:  led_q <= 4'b0010;
        ST_MID:  led_q <= 4'b0100;
        default: led_q <= 4'b1000;
      endcase
    end
  end

  assign o_Led = led_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed testbench for fan_speed_ctrl. Expected LED patterns are pushed to a
// scoreboard queue when each stimulus step is driven and popped when it is checked.
module tb_fan_speed_ctrl;

  localparam int DEB = 100;

  logic       clk;
  logic       rst;
  logic [4:0] btn;
  logic [3:0] led;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q [$];
  logic [3:0] cur_led;

  fan_speed_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_button(btn),
    .o_Led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a button pattern just after a rising edge, hold it for 'hold' clocks and check
  // the LEDs: final value, one-hot every cycle, no spurious change, and settle latency.
  task automatic step(input logic [4:0] b, input int hold, input logic [3:0] exp_led,
                      input string tag);
    int settle;
    int unstable;
    int bad_hot;
    logic [3:0] want;
    settle   = -1;
    unstable = 0;
    bad_hot  = 0;
    @(posedge clk);
    #1 btn = b;
    exp_q.push_back(exp_led);
    for (int n = 1; n <= hold; n++) begin
      @(negedge clk);
      if (!$onehot(led)) bad_hot++;
      if (settle < 0) begin
        if (led === exp_led) settle = n;
        else if (led !== cur_led) unstable++;
      end else if (led !== exp_led) begin
        unstable++;
      end
    end
    want = exp_q.pop_front();
    checks++;
    assert (led === want) else begin
      errors++;
      $error("FAIL %s final: led=%b expected=%b", tag, led, want);
    end
    checks++;
    assert (bad_hot == 0) else begin
      errors++;
      $error("FAIL %s onehot: bad_cycles=%0d expected=0", tag, bad_hot);
    end
    checks++;
    assert (unstable == 0) else begin
      errors++;
      $error("FAIL %s stable: stray_cycles=%0d expected=0", tag, unstable);
    end
    if (exp_led !== cur_led) begin
      checks++;
      assert (settle >= DEB && settle <= DEB + 5) else begin
        errors++;
        $error("FAIL %s latency: settle=%0d expected=%0d..%0d", tag, settle, DEB, DEB + 5);
      end
    end
    cur_led = exp_led;
  endtask

  initial begin
    int bad;
    logic [3:0] want;

    // Reset held with OFF button pressed: LEDs must read OFF throughout.
    rst = 1'b1;
    btn = 5'b00001;
    cur_led = 4'b0001;
    exp_q.push_back(4'b0001);
    bad = 0;
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      if (led !== 4'b0001) bad++;
    end
    want = exp_q.pop_front();
    checks++;
    assert (bad == 0 && led === want) else begin
      errors++;
      $error("FAIL reset_hold: bad_cycles=%0d led=%b expected=%b", bad, led, want);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step(5'b00000, 2500, 4'b0001, "reset_release");

    // Direct presses.
    step(5'b00001, 2500, 4'b0001, "press_off");
    step(5'b00010, 2500, 4'b0010, "press_low");
    step(5'b00100, 2500, 4'b0100, "press_mid");
    step(5'b01000, 2500, 4'b1000, "press_high");

    // CYCLE from HIGH wraps to OFF exactly once while held, then HIGH again.
    step(5'b10000, 2500, 4'b0001, "cycle_wrap");
    step(5'b01000, 2500, 4'b1000, "high_again");

    // CYCLE through LOW and MID as well.
    step(5'b00001, 300, 4'b0001, "to_off");
    step(5'b10000, 300, 4'b0010, "cycle_off_low");
    step(5'b00000, 300, 4'b0010, "rel1");
    step(5'b10000, 300, 4'b0100, "cycle_low_mid");
    step(5'b00000, 300, 4'b0100, "rel2");

    // Glitch shorter than debounce must be ignored.
    step(5'b00001, 300, 4'b0001, "glitch_setup");
    step(5'b00000, 300, 4'b0001, "glitch_idle");
    step(5'b00010, DEB / 2, 4'b0001, "glitch_pulse");
    step(5'b00000, 300, 4'b0001, "glitch_after");

    // Simultaneous presses: lowest index wins.
    step(5'b00100, 300, 4'b0100, "sim_setup_mid");
    step(5'b00000, 300, 4'b0100, "rel3");
    step(5'b01001, 300, 4'b0001, "sim_off_high");
    step(5'b00000, 300, 4'b0001, "rel4");
    step(5'b10100, 300, 4'b0100, "sim_mid_cycle");
    step(5'b00000, 300, 4'b0100, "rel5");

    // Reset in mid-operation from HIGH.
    step(5'b01000, 300, 4'b1000, "mid_rst_setup");
    step(5'b00000, 300, 4'b1000, "rel6");
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(4'b0001);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    assert (led === want) else begin
      errors++;
      $error("FAIL mid_reset: led=%b expected=%b", led, want);
    end
    cur_led = 4'b0001;
    step(5'b00100, 2500, 4'b0100, "after_reset_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
